// File: rtl/persiana_motor_driver.sv
// H-bridge driver for the blind motor: dead-time interlock on every stop or reversal,
// PWM soft-start ramp, and a latched fault when travel runs too long without an end-stop.
module persiana_motor_driver #(
   parameter int DEAD_CYCLES      = 16,
   parameter int PWM_BITS         = 4,
   parameter int RAMP_STEP_CYCLES = 8,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       subir,
   input  logic       bajar,
   input  logic       Ssup,
   input  logic       Sinf,
   input  logic       fault_clr,
   output logic       mot_a,
   output logic       mot_b,
   output logic       fault,
   output logic       busy,
   output logic [2:0] st
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN_UP = 3'd1,
      RUN_DN = 3'd2,
      DEAD   = 3'd3,
      FAULT  = 3'd4
   } state_t;

   localparam int RUN_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
   localparam int RAMP_W = $clog2(RAMP_STEP_CYCLES + 1);

   localparam logic [RUN_W-1:0]    RUN_LAST  = RUN_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_MIN  = PWM_BITS'(1);

   state_t              state_q, state_d;
   logic [RUN_W-1:0]    runCnt_q, runCnt_d;
   logic [DEAD_W-1:0]   deadCnt_q, deadCnt_d;
   logic [RAMP_W-1:0]   rampCnt_q, rampCnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
   logic                motA_q, motA_d;
   logic                motB_q, motB_d;
   logic                fault_q, fault_d;
   logic                busy_q, busy_d;

   logic upReq, dnReq, runReq, pwmOn;

   // Simultaneous raise and lower cancel each other out, so a conflict looks like a release.
   assign upReq = subir & ~bajar & ~Ssup;
   assign dnReq = bajar & ~subir & ~Sinf;

   always_comb begin
      state_d   = state_q;
      runCnt_d  = runCnt_q;
      deadCnt_d = deadCnt_q;
      rampCnt_d = rampCnt_q;
      duty_d    = duty_q;
      pwmCnt_d  = pwmCnt_q + PWM_BITS'(1);
      runReq    = (state_q == RUN_UP) ? upReq : dnReq;

      case (state_q)
         IDLE: begin
            if (upReq || dnReq) begin
               state_d   = upReq ? RUN_UP : RUN_DN;
               runCnt_d  = '0;
               rampCnt_d = '0;
               duty_d    = DUTY_MIN;
            end
         end
         RUN_UP, RUN_DN: begin
            // Dropping the request wins over the timeout so a normal stop never faults.
            if (!runReq) begin
               state_d   = DEAD;
               deadCnt_d = '0;
               duty_d    = '0;
            end else if (runCnt_q == RUN_LAST) begin
               state_d = FAULT;
               duty_d  = '0;
            end else begin
               runCnt_d = runCnt_q + RUN_W'(1);
               if (rampCnt_q == RAMP_LAST) begin
                  rampCnt_d = '0;
                  if (duty_q != DUTY_MAX) duty_d = duty_q + PWM_BITS'(1);
               end else begin
                  rampCnt_d = rampCnt_q + RAMP_W'(1);
               end
            end
         end
         DEAD: begin
            if (deadCnt_q == DEAD_LAST) state_d = IDLE;
            else                        deadCnt_d = deadCnt_q + DEAD_W'(1);
         end
         FAULT: begin
            if (fault_clr && !subir && !bajar) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            duty_d  = '0;
         end
      endcase

      // Outputs are precomputed from next-state values so they leave the block registered.
      pwmOn   = (duty_d == DUTY_MAX) || (pwmCnt_d < duty_d);
      motA_d  = (state_d == RUN_UP) && pwmOn;
      motB_d  = (state_d == RUN_DN) && pwmOn;
      fault_d = (state_d == FAULT);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         runCnt_q  <= '0;
         deadCnt_q <= '0;
         rampCnt_q <= '0;
         duty_q    <= '0;
         pwmCnt_q  <= '0;
         motA_q    <= 1'b0;
         motB_q    <= 1'b0;
         fault_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         runCnt_q  <= runCnt_d;
         deadCnt_q <= deadCnt_d;
         rampCnt_q <= rampCnt_d;
         duty_q    <= duty_d;
         pwmCnt_q  <= pwmCnt_d;
         motA_q    <= motA_d;
         motB_q    <= motB_d;
         fault_q   <= fault_d;
         busy_q    <= busy_d;
      end
   end

   assign mot_a = motA_q;
   assign mot_b = motB_q;
   assign fault = fault_q;
   assign busy  = busy_q;
   assign st    = state_q;

endmodule

// File: doc/persiana_motor_driver.md
# persiana_motor_driver

H-bridge drive stage directly downstream of the blind FSM: consumes its `subir`/`bajar` commands and the end-stop sensors and produces the two motor-leg enables. Enforces a dead-time interlock on every stop or reversal, soft-starts the motor with a PWM duty ramp, and latches a fault if travel exceeds a timeout without reaching an end-stop. All inputs are synchronous to `clk`.

## Interface
Parameters:
- `DEAD_CYCLES`, 16: cycles both legs are held off after any stop or reversal (≥1).
- `PWM_BITS`, 4: width of PWM counter and duty; `MAX = 2^PWM_BITS - 1`.
- `RAMP_STEP_CYCLES`, 8: cycles in RUN between duty increments (≥1).
- `TIMEOUT_CYCLES`, 1024: maximum cycles allowed in one RUN state (≥2).

Ports:
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high; overrides all other inputs.
- `subir` in 1: raise request from blind FSM.
- `bajar` in 1: lower request from blind FSM.
- `Ssup` in 1: upper end-stop, 1 = blind fully up.
- `Sinf` in 1: lower end-stop, 1 = blind fully down.
- `fault_clr` in 1: clears latched fault.
- `mot_a` out 1: up-leg drive (PWM-gated).
- `mot_b` out 1: down-leg drive (PWM-gated).
- `fault` out 1: timeout fault latched.
- `busy` out 1: state ≠ IDLE.
- `st` out 3: state code.

## Operation
- States / `st` codes: IDLE=0, RUN_UP=1, RUN_DN=2, DEAD=3, FAULT=4.
- `up_req = subir & ~bajar & ~Ssup`; `dn_req = bajar & ~subir & ~Sinf`. Both requests high is illegal and treated as no request.
- IDLE: `up_req` → RUN_UP; else `dn_req` → RUN_DN; else stay.
- RUN_UP: `~up_req` → DEAD (covers release, end-stop reached, conflict, reversal). Else if `run_cnt == TIMEOUT_CYCLES-1` → FAULT. Else stay. RUN_DN is symmetric with `dn_req`.
- DEAD: `dead_cnt` loaded with 0 on entry and incremented each cycle; at `dead_cnt == DEAD_CYCLES-1` → IDLE. Requests are ignored in DEAD, so a reversal always costs DEAD_CYCLES + 1 idle cycle before the new direction runs.
- FAULT: `fault`=1, both legs off; `fault_clr & ~subir & ~bajar` → IDLE; otherwise stay.
- Priority in RUN: a stop (→DEAD) beats a timeout in the same cycle.
- `run_cnt` is cleared on RUN entry and increments each RUN cycle, so the maximum RUN dwell is TIMEOUT_CYCLES cycles.
- Duty: set to 1 on RUN entry. Increments by 1 every RAMP_STEP_CYCLES RUN cycles and saturates at MAX. Forced to 0 outside RUN.
- PWM: `pwm_cnt` is PWM_BITS wide, free-running, and wraps MAX→0. `pwm_on = (duty == MAX) | (pwm_cnt < duty)`.
- `mot_a = (st==RUN_UP) & pwm_on`; `mot_b = (st==RUN_DN) & pwm_on`. `mot_a & mot_b` is never 1.
- Outputs decode from registers only; there is no combinational path from inputs to outputs.

## Timing
- Reset: on the edge with `reset`=1 → IDLE, all counters 0, duty 0. Outputs `mot_a`=`mot_b`=`fault`=`busy`=0, `st`=0, visible the cycle after that edge. Reset mid-RUN or mid-FAULT behaves the same, with no dead-time guarantee beyond the reset itself.
- Start latency: request sampled high in IDLE → RUN state and first possible drive on the next cycle.
- Stop latency: request drop or end-stop sampled at edge N → the leg is off from edge N (state DEAD). Both legs stay off for exactly DEAD_CYCLES cycles, then 1 cycle in IDLE.
- Ramp: duty reaches MAX after `(MAX-1)*RAMP_STEP_CYCLES` RUN cycles.
- Fault: with a request held and no end-stop, FAULT is entered TIMEOUT_CYCLES cycles after RUN entry. `fault_clr` → IDLE on the next edge, provided both requests are low.

## Test plan
Bench parameters: DEAD_CYCLES=4, PWM_BITS=3, RAMP_STEP_CYCLES=2, TIMEOUT_CYCLES=32.
- Reset → `st`=0, `mot_a`=`mot_b`=`fault`=`busy`=0; `reset` asserted mid-RUN_UP → IDLE next cycle with `mot_a`=0.
- `subir`=1, `Ssup`=0 → `st`=1 next cycle. Duty steps 1,2,…,7 every 2 cycles. `mot_a` high count per 8-cycle PWM period equals duty (8 at MAX). `mot_b`=0 throughout.
- RUN_UP, then `Ssup`→1 → `st`=3 the next cycle, `mot_a`=0, 4 cycles in DEAD, then `st`=0. Holding `subir`=1 does not restart the motor.
- Reversal: in RUN_UP switch to `bajar`=1, `subir`=0 → DEAD 4 cycles, IDLE 1 cycle, then RUN_DN. `mot_a` and `mot_b` are never high together.
- `subir`=`bajar`=1 from IDLE → stays IDLE; the same conflict during RUN_DN → DEAD.
- `bajar` held with `Sinf`=0 for 32 cycles → `st`=4, `fault`=1. `fault_clr`=1 with `bajar`=1 → stays FAULT. With `bajar`=0 → IDLE, `fault`=0.
